// File: rtl/id_ex_issue_ctrl.sv
// ID/EX issue control: load-use stall sequencing and branch flush for the ID/EX register.
// Define ISSUE_STATS_EN to build the saturating StallCycles/FlushEvents counters.
module id_ex_issue_ctrl #(
  parameter logic [1:0]  LOAD_SEL       = 2'b01,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned STAT_W         = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [4:0] ID_RSAddr,
  input  logic [4:0] ID_RTAddr,
  input  logic       ID_UsesRS,
  input  logic       ID_UsesRT,
  input  logic       EX_RegWriteEN,
  input  logic [1:0] EX_Mem2RegSEL,
  input  logic [4:0] EX_DstAddr,
  input  logic       EX_BranchTaken,
  output logic       PCWriteEN,
  output logic       IFIDWriteEN,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       StallActive
`ifdef ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] StallCycles,
  output logic [STAT_W-1:0] FlushEvents
`endif
);

  typedef enum logic {IDLE, STALL} state_e;

  localparam logic [1:0] CNT_INIT = 2'((LOAD_USE_STALL >= 2) ? (LOAD_USE_STALL - 2) : 0);

  if ((LOAD_USE_STALL < 1) || (LOAD_USE_STALL > 3) || (STAT_W < 1)) begin : g_bad_param
    $error("id_ex_issue_ctrl: LOAD_USE_STALL must be 1..3 and STAT_W >= 1");
  end

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       haz;
  logic       stall_evt;
  logic       flush_evt;

  always_comb begin
    haz = EX_RegWriteEN && (EX_Mem2RegSEL == LOAD_SEL) && (EX_DstAddr != 5'd0) &&
          ((ID_UsesRS && (ID_RSAddr == EX_DstAddr)) ||
           (ID_UsesRT && (ID_RTAddr == EX_DstAddr)));

    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWriteEN   = 1'b1;
    IFIDWriteEN = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    StallActive = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    // A taken branch wins in either state; in STALL it also aborts the sequence.
    if (EX_BranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      flush_evt  = 1'b1;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (state_q == STALL) begin
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IDEXBubble  = 1'b1;
      StallActive = 1'b1;
      stall_evt   = 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (haz) begin
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IDEXBubble  = 1'b1;
      StallActive = 1'b1;
      stall_evt   = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_d = STALL;
        cnt_d   = CNT_INIT;
      end
    end

    // Reset values appear on the outputs as soon as RESET falls, not at the next edge.
    if (!RESET) begin
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      StallActive = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ISSUE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushEvents = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: doc/id_ex_issue_ctrl.md
Name: id_ex_issue_ctrl

Overview:
- Producer-side control for the ID/EX pipeline register. Decides each cycle whether the decoded ID instruction is issued into ID/EX, replaced by a bubble, or flushed.
- Detects load-use hazards against the instruction currently in EX and sequences multi-cycle stalls with a small FSM. Handles flushes for branches resolved in EX.
- Drives PC / IF-ID write enables and the ID/EX bubble select. Sits between the decoder/register file and the ID/EX register.

Parameters:
- LOAD_SEL, 2'b01: Mem2RegSEL encoding that marks an instruction as a load (memory data to register).
- LOAD_USE_STALL, 1: bubble cycles inserted per load-use hazard; legal range 1..3.
- STAT_W, 16: width of the statistics counters (optional feature only).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ID_RSAddr  in  5  rs field of the ID instruction.
- ID_RTAddr  in  5  rt field of the ID instruction.
- ID_UsesRS  in  1  ID instruction reads rs.
- ID_UsesRT  in  1  ID instruction reads rt.
- EX_RegWriteEN  in  1  RegWriteEN at the ID/EX output.
- EX_Mem2RegSEL  in  2  Mem2RegSEL at the ID/EX output.
- EX_DstAddr  in  5  destination register of the EX instruction, after the RegDst mux.
- EX_BranchTaken  in  1  Beq/Bne in EX evaluated taken this cycle.
- PCWriteEN  out  1  PC may update.
- IFIDWriteEN  out  1  IF/ID register may load.
- IFIDFlush  out  1  IF/ID loads a NOP.
- IDEXBubble  out  1  ID/EX loads all-zero control (RegWriteEN, MemWriteEN, Beq, Bne = 0).
- StallActive  out  1  a stall is in progress (state STALL, or a hazard detected this cycle).
- StallCycles  out  STAT_W  saturating count of bubble cycles (optional feature only).
- FlushEvents  out  STAT_W  saturating count of branch flushes (optional feature only).

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, cnt=0.
  - Outputs forced to PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXBubble=1, StallActive=0, stats=0.
  - Reset asserted mid-stall aborts the stall immediately.
- Hazard, combinational: haz = EX_RegWriteEN & (EX_Mem2RegSEL==LOAD_SEL) & (EX_DstAddr!=0) & ((ID_UsesRS & ID_RSAddr==EX_DstAddr) | (ID_UsesRT & ID_RTAddr==EX_DstAddr)).
- Register $0 never causes a hazard.
- Outputs are Mealy: registered state plus current inputs, so there is zero-cycle latency from hazard to stall.
- State IDLE:
  - EX_BranchTaken=1 (highest priority): PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=1, IDEXBubble=1. Stay in IDLE.
  - else haz=1: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1, StallActive=1.
    - LOAD_USE_STALL=1: stay in IDLE.
    - LOAD_USE_STALL>1: go to STALL with cnt=LOAD_USE_STALL-2.
  - else: PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=0, IDEXBubble=0 (normal issue).
- State STALL:
  - Outputs: PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1, StallActive=1.
  - haz is not re-evaluated here, because the load has already left EX.
  - cnt=0: next state IDLE; else cnt decrements.
  - EX_BranchTaken=1 in STALL cannot legally occur, since the bubbles in EX are not branches. If it is asserted anyway: apply the branch-flush outputs, abort to IDLE, cnt=0.
- Back-to-back loads: a new hazard detected on the first IDLE cycle after a stall starts a fresh stall sequence. There is no merging of stalls.
- Hold semantics: IFIDWriteEN=0 and PCWriteEN=0 always assert together. IFIDFlush=1 overrides IFIDWriteEN=0 only in the reset/branch cases.

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined:
  - StallCycles increments on every cycle with IDEXBubble=1 due to a hazard or STALL.
  - FlushEvents increments on every cycle with EX_BranchTaken=1 accepted.
  - Both counters saturate at all-ones, clear on reset, and do not wrap.
- Undefined: both ports are absent and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset release, then EX_RegWriteEN=0 for 5 cycles -> PCWriteEN=IFIDWriteEN=1, IDEXBubble=0, IFIDFlush=0 on every cycle; during reset, IDEXBubble=1 and IFIDFlush=1.
- LOAD_USE_STALL=1; EX load to $8 (Mem2RegSEL=01, RegWriteEN=1); ID uses rs=$8 -> exactly 1 cycle with PCWriteEN=0, IFIDWriteEN=0, IDEXBubble=1; next cycle (EX now a bubble) normal issue.
- LOAD_USE_STALL=3, same hazard on rt=$8 -> 3 consecutive bubble cycles, StallActive=1 throughout, then IDLE. Repeat with EX_DstAddr=0 -> no stall.
- EX_BranchTaken=1 coinciding with a load-use hazard -> IFIDFlush=1, IDEXBubble=1, PCWriteEN=1, no stall; state stays IDLE.
- LOAD_USE_STALL=3; drop RESET to 0 asynchronously during the 2nd stall cycle -> outputs take reset values immediately; after release, normal issue with no residual stall.
- ISSUE_STATS_EN, STAT_W=2; 5 single-cycle hazards -> StallCycles saturates at 3. 2 taken branches -> FlushEvents=2.
